// File: rtl/axis_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_write_ctrl_pkg
//  Description : Shared AXI encodings and FSM state encoding for the
//                write-side controller and its outstanding-burst counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_write_ctrl_pkg;

    // AXI burst type and response encodings
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // One-hot FSM bit positions
    localparam int ST_IDLE_BIT = 0;
    localparam int ST_LOAD_BIT = 1;
    localparam int ST_ADDR_BIT = 2;
    localparam int ST_RESP_BIT = 3;
    localparam int ST_DONE_BIT = 4;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_LOAD = 5'b00010,
        ST_ADDR = 5'b00100,
        ST_RESP = 5'b01000,
        ST_DONE = 5'b10000
    } state_t;

endpackage : axis_write_ctrl_pkg
`default_nettype wire

// File: rtl/axis_outstanding_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : axis_outstanding_cnt
//  Description : Counts AW bursts still waiting for a B response. Increments
//                on inc, decrements on dec, holds when both fire together.
//                A dec with nothing outstanding is a stray response and is
//                ignored so the count never underflows.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_outstanding_cnt
    import axis_write_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic dec_eff;
    logic inc_eff;

    // Stray responses are dropped; an increment at the limit only lands if a
    // response frees a slot in the same cycle.
    assign dec_eff = dec && (count != '0);
    assign inc_eff = inc && ((count != MAX_CNT) || dec_eff);
    assign full    = (count >= MAX_CNT);

    // Up/down counter; simultaneous inc and dec leave it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc_eff && !dec_eff) begin
            count <= count + ONE;
        end else if (dec_eff && !inc_eff) begin
            count <= count - ONE;
        end
    end

endmodule : axis_outstanding_cnt
`default_nettype wire

// File: rtl/axis_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axis_write_ctrl
//  Description : Accepts one transfer command, hands its length to the
//                write-data stage, splits the transfer into INCR bursts on AW,
//                tracks outstanding bursts on B and pulses done at the end.
//                Optional macro AXIS_WRITE_CTRL_ERR_EN enables the sticky
//                err flag for non-OKAY write responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_write_ctrl
    import axis_write_ctrl_pkg::*;
#(
    parameter int CFG_DWIDTH      = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 8,
    parameter int CONVERT_SHIFT   = 3,
    parameter int WIDTH_RATIO     = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_address,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [CFG_DWIDTH-1:0]     wr_length,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic [2:0]                axi_awsize,
    output logic [1:0]                axi_awburst,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic                      done,
    output logic                      err
);

    localparam int RATIO_SHIFT = $clog2(WIDTH_RATIO);
    localparam int CNT_W       = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CFG_DWIDTH-1:0] BURST_BEATS = CFG_DWIDTH'(1) << AXI_LEN_WIDTH;
    localparam logic [CFG_DWIDTH-1:0] ONE_BEAT    = CFG_DWIDTH'(1);

    state_t                state;
    logic [CFG_DWIDTH-1:0] beats_left;
    logic [CFG_DWIDTH-1:0] burst_next;
    logic [CFG_DWIDTH-1:0] cfg_beats;
    logic [CNT_W-1:0]      outstanding;
    logic                  cnt_full;
    logic                  aw_fire;
    logic                  b_fire;

    assign axi_awsize  = 3'(CONVERT_SHIFT);
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_bready  = 1'b1;
    assign cfg_ready   = state[ST_IDLE_BIT];

    assign cfg_beats  = cfg_length >> RATIO_SHIFT;
    // beats_left is frozen while awvalid is up, so this stays valid through
    // the handshake and doubles as the step size once it completes
    assign burst_next = (beats_left > BURST_BEATS) ? BURST_BEATS : beats_left;
    assign aw_fire    = axi_awvalid && axi_awready;
    assign b_fire     = axi_bvalid && axi_bready;

    axis_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_outstanding_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (aw_fire),
        .dec   (b_fire),
        .count (outstanding),
        .full  (cnt_full)
    );

    // Transfer sequencer: command latch, length handoff, burst issue, drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_valid    <= 1'b0;
            wr_length   <= '0;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            beats_left  <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        axi_awaddr <= cfg_address;
                        wr_length  <= cfg_length;
                        beats_left <= cfg_beats;
                        if (cfg_beats == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            wr_valid <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (axi_awvalid) begin
                        if (axi_awready) begin
                            axi_awvalid <= 1'b0;
                            axi_awaddr  <= axi_awaddr + AXI_ADDR_WIDTH'(burst_next << CONVERT_SHIFT);
                            beats_left  <= beats_left - burst_next;
                            if (beats_left == burst_next) begin
                                state <= ST_RESP;
                            end
                        end
                    end else if ((beats_left != '0) && !cnt_full) begin
                        axi_awvalid <= 1'b1;
                        axi_awlen   <= AXI_LEN_WIDTH'(burst_next - ONE_BEAT);
                    end
                end
                ST_RESP: begin
                    if (outstanding == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_WRITE_CTRL_ERR_EN
    // Sticky response error; a new error wins over the clear on command accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (b_fire && (axi_bresp != AXI_RESP_OKAY)) begin
            err <= 1'b1;
        end else if (cfg_valid && state[ST_IDLE_BIT]) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_bresp;
    assign unused_bresp = ^axi_bresp;
    assign err          = 1'b0;
`endif

endmodule : axis_write_ctrl
`default_nettype wire

// File: tb/tb_axis_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_write_ctrl
//  Description : Directed self-checking bench for axis_write_ctrl, built with
//                MAX_OUTSTANDING=2 so the outstanding limit is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_write_ctrl;

`ifdef AXIS_WRITE_CTRL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_address;
    logic [31:0] cfg_length;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] wr_length;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    axis_write_ctrl #(
        .CFG_DWIDTH      (32),
        .AXI_ADDR_WIDTH  (32),
        .AXI_LEN_WIDTH   (8),
        .CONVERT_SHIFT   (3),
        .WIDTH_RATIO     (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_address (cfg_address),
        .cfg_length  (cfg_length),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .wr_length   (wr_length),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] l);
        cfg_address = a;
        cfg_length  = l;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic wait_aw(input string tag);
        for (int i = 0; i < 30 && !axi_awvalid; i++) tick();
        chk(tag, axi_awvalid, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 30 && !done; i++) tick();
        chk(tag, done, 1'b1);
    endtask

    task automatic pulse_b(input logic [1:0] resp);
        axi_bvalid = 1'b1;
        axi_bresp  = resp;
        tick();
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
    endtask

    // Counts done pulses and AW handshakes over n cycles
    task automatic run_count(input int n, output int dn, output int hs);
        dn = 0;
        hs = 0;
        for (int i = 0; i < n; i++) begin
            if (done) dn++;
            if (axi_awvalid && axi_awready) hs++;
            tick();
        end
    endtask

    initial begin
        int dn;
        int hs;
        int hs_total;
        logic stable;

        rst         = 1'b1;
        cfg_address = '0;
        cfg_length  = '0;
        cfg_valid   = 1'b0;
        wr_ready    = 1'b1;
        axi_awready = 1'b1;
        axi_bresp   = 2'b00;
        axi_bvalid  = 1'b0;
        tick();
        tick();

        // Reset state and constant outputs
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_awvalid", axi_awvalid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_awaddr", axi_awaddr, 32'h0);
        chk("rst_awlen", axi_awlen, 8'h0);
        chk("rst_wr_length", wr_length, 32'h0);
        chk("awsize", axi_awsize, 3'd3);
        chk("awburst", axi_awburst, 2'b01);
        chk("bready", axi_bready, 1'b1);
        rst = 1'b0;
        tick();

        // 16 words at 0x1000: single 8-beat burst
        start(32'h1000, 32'd16);
        chk("t1_cfg_ready_busy", cfg_ready, 1'b0);
        chk("t1_wr_valid", wr_valid, 1'b1);
        chk("t1_wr_length", wr_length, 32'd16);
        wait_aw("t1_aw");
        chk("t1_awaddr", axi_awaddr, 32'h1000);
        chk("t1_awlen", axi_awlen, 8'd7);
        tick();
        chk("t1_awvalid_drop", axi_awvalid, 1'b0);
        run_count(5, dn, hs);
        chk("t1_no_done_before_b", dn, 0);
        pulse_b(2'b00);
        run_count(6, dn, hs);
        chk("t1_done_once", dn, 1);
        chk("t1_idle", cfg_ready, 1'b1);

        // 1040 words: 520 beats -> 256, 256, 8 with two-deep outstanding limit
        start(32'h0, 32'd1040);
        wait_aw("t2_aw1");
        chk("t2_awaddr1", axi_awaddr, 32'h0);
        chk("t2_awlen1", axi_awlen, 8'd255);
        tick();
        wait_aw("t2_aw2");
        chk("t2_awaddr2", axi_awaddr, 32'h800);
        chk("t2_awlen2", axi_awlen, 8'd255);
        tick();
        run_count(4, dn, hs);
        chk("t2_limit_no_aw", hs, 0);
        chk("t2_limit_awvalid_low", axi_awvalid, 1'b0);
        pulse_b(2'b00);
        wait_aw("t2_aw3");
        chk("t2_awaddr3", axi_awaddr, 32'h1000);
        chk("t2_awlen3", axi_awlen, 8'd7);
        tick();
        run_count(4, dn, hs);
        chk("t2_no_done_2b_left", dn, 0);
        pulse_b(2'b00);
        run_count(4, dn, hs);
        chk("t2_no_done_1b_left", dn, 0);
        pulse_b(2'b00);
        run_count(6, dn, hs);
        chk("t2_done_after_3rd_b", dn, 1);

        // 2048 words: 4 bursts queued, B withheld -> exactly 2 handshakes
        start(32'h10000, 32'd2048);
        run_count(12, dn, hs);
        chk("t3_two_aw_only", hs, 2);
        chk("t3_awvalid_low", axi_awvalid, 1'b0);
        hs_total = 0;
        dn = 0;
        axi_bvalid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                dn++;
                break;
            end
            if (axi_awvalid && axi_awready) hs_total++;
            tick();
        end
        axi_bvalid = 1'b0;
        chk("t3_remaining_aw", hs_total, 2);
        chk("t3_done", dn, 1);
        chk("t3_final_awaddr", axi_awaddr, 32'h12000);
        tick();
        chk("t3_done_one_cycle", done, 1'b0);

        // awready held low for 5 cycles: AW must hold steady
        axi_awready = 1'b0;
        start(32'h2000, 32'd16);
        wait_aw("t4_aw");
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!axi_awvalid || axi_awaddr !== 32'h2000 || axi_awlen !== 8'd7) stable = 1'b0;
            tick();
        end
        chk("t4_aw_stable", stable, 1'b1);
        axi_awready = 1'b1;
        tick();
        chk("t4_aw_taken", axi_awvalid, 1'b0);
        pulse_b(2'b00);
        wait_done("t4_done");
        tick();

        // wr_ready held low: no AW before length handoff
        wr_ready = 1'b0;
        start(32'h3000, 32'd8);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!wr_valid || axi_awvalid) stable = 1'b0;
            tick();
        end
        chk("t5_hold_no_aw", stable, 1'b1);
        chk("t5_wr_length", wr_length, 32'd8);
        wr_ready = 1'b1;
        tick();
        chk("t5_wr_valid_drop", wr_valid, 1'b0);
        wait_aw("t5_aw");
        chk("t5_awaddr", axi_awaddr, 32'h3000);
        chk("t5_awlen", axi_awlen, 8'd3);
        tick();
        pulse_b(2'b00);
        wait_done("t5_done");
        tick();

        // Simultaneous AW and B handshake keeps the count
        start(32'h4000, 32'd1024);
        wait_aw("t6_aw1");
        tick();
        wait_aw("t6_aw2");
        chk("t6_awaddr2", axi_awaddr, 32'h4800);
        axi_bvalid = 1'b1;
        tick();
        axi_bvalid = 1'b0;
        chk("t6_outstanding", dut.outstanding, 1);
        run_count(5, dn, hs);
        chk("t6_no_early_done", dn, 0);
        pulse_b(2'b00);
        run_count(6, dn, hs);
        chk("t6_done", dn, 1);

        // Stray B in IDLE
        pulse_b(2'b00);
        run_count(3, dn, hs);
        chk("t7_stray_no_done", dn, 0);
        chk("t7_stray_idle", cfg_ready, 1'b1);
        chk("t7_stray_count", dut.outstanding, 0);

        // Error response on burst 2
        start(32'h8000, 32'd1024);
        wait_aw("t8_aw1");
        tick();
        wait_aw("t8_aw2");
        tick();
        pulse_b(2'b00);
        chk("t8_err_after_okay", err, 1'b0);
        pulse_b(2'b10);
        chk("t8_err_set", err, ERR_EXP);
        wait_done("t8_done");
        chk("t8_err_at_done", err, ERR_EXP);
        tick();
        chk("t8_err_held_idle", err, ERR_EXP);

        // Zero-length command: straight to done, err cleared on accept
        start(32'h5000, 32'd0);
        chk("t9_zero_done", done, 1'b1);
        chk("t9_zero_no_wr_valid", wr_valid, 1'b0);
        chk("t9_err_cleared", err, 1'b0);
        tick();
        chk("t9_zero_done_drop", done, 1'b0);
        chk("t9_zero_idle", cfg_ready, 1'b1);

        // Async reset mid-burst, then the in-flight B is absorbed
        start(32'h6000, 32'd16);
        wait_aw("t10_aw");
        #2;
        rst = 1'b1;
        #1;
        chk("t10_async_awvalid", axi_awvalid, 1'b0);
        chk("t10_async_idle", cfg_ready, 1'b1);
        chk("t10_async_awaddr", axi_awaddr, 32'h0);
        #1;
        rst = 1'b0;
        tick();
        pulse_b(2'b00);
        run_count(3, dn, hs);
        chk("t10_stray_no_done", dn, 0);
        start(32'h7000, 32'd4);
        wait_aw("t10_aw_after");
        chk("t10_awaddr_after", axi_awaddr, 32'h7000);
        chk("t10_awlen_after", axi_awlen, 8'd1);
        tick();
        pulse_b(2'b00);
        run_count(6, dn, hs);
        chk("t10_done_after", dn, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_axis_write_ctrl
`default_nettype wire
